// File: rtl/sram_1p_arb.sv
// rtl/sram_1p_arb.sv - Round-robin arbiter and read-response router for one single-port RAM.
// Optional idle-time scrubber is built when SRAM_1P_ARB_SCRUB_EN is defined.
module sram_1p_arb #(
    parameter int Depth         = 512,
    parameter int Width         = 32,
    parameter int Latency       = 1,
    parameter int ScrubInterval = 1024,
    localparam int Aw           = (Depth == 1) ? 1 : $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_req_i,
    output logic             a_gnt_o,
    input  logic             a_we_i,
    input  logic [Aw-1:0]    a_addr_i,
    input  logic [Width-1:0] a_wdata_i,
    input  logic [Width-1:0] a_wmask_i,
    output logic             a_rvalid_o,
    output logic [Width-1:0] a_rdata_o,
    output logic [1:0]       a_rerror_o,
    input  logic             b_req_i,
    output logic             b_gnt_o,
    input  logic             b_we_i,
    input  logic [Aw-1:0]    b_addr_i,
    input  logic [Width-1:0] b_wdata_i,
    input  logic [Width-1:0] b_wmask_i,
    output logic             b_rvalid_o,
    output logic [Width-1:0] b_rdata_o,
    output logic [1:0]       b_rerror_o,
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic             ram_rvalid_i,
    input  logic [Width-1:0] ram_rdata_i,
    input  logic [1:0]       ram_rerror_i,
    output logic             proto_err_o,
    output logic [15:0]      scrub_cnt_o
);
    localparam logic [1:0] ID_A = 2'd0;
    localparam logic [1:0] ID_B = 2'd1;

    logic             last_b_q, last_b_d;
    logic             a_gnt, b_gnt;
    logic             push_v;
    logic [1:0]       push_id;
    logic [Latency-1:0] tv_q;
    logic [1:0]       tid_q [Latency];
    logic [1:0]       blank_q;
    logic             proto_err_q;
    logic             tail_v;
    logic [1:0]       tail_id;
    logic             rsp_v;

    assign a_gnt   = ~rst_i & a_req_i & (~b_req_i | last_b_q);
    assign b_gnt   = ~rst_i & b_req_i & ~a_gnt;
    assign a_gnt_o = a_gnt;
    assign b_gnt_o = b_gnt;

    always_comb begin
        last_b_d = last_b_q;
        if (a_gnt)      last_b_d = 1'b0;
        else if (b_gnt) last_b_d = 1'b1;
    end

`ifdef SRAM_1P_ARB_SCRUB_EN
    localparam logic [1:0] ID_SCRUB = 2'd2;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RD     = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [15:0]      icnt_q, icnt_d;
    logic [15:0]      scnt_q, scnt_d;
    logic [Aw-1:0]    saddr_q, saddr_d;
    logic [Aw-1:0]    waddr_q, waddr_d;
    logic [Width-1:0] wbdata_q, wbdata_d;
    logic             cancel_q, cancel_d;
    logic             ab_req, s_gnt, s_rsp, ab_wr_hit;

    assign ab_req    = a_req_i | b_req_i;
    assign s_gnt     = ~rst_i & ~ab_req & ((state_q == S_RD) | (state_q == S_WB));
    assign s_rsp     = rsp_v & (tail_id == ID_SCRUB);
    assign ab_wr_hit = (a_gnt & a_we_i & (a_addr_i == waddr_q)) |
                       (b_gnt & b_we_i & (b_addr_i == waddr_q));
`endif

    always_comb begin
        ram_req_o   = 1'b0;
        ram_write_o = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        push_v      = 1'b0;
        push_id     = ID_A;
        if (a_gnt) begin
            ram_req_o   = 1'b1;
            ram_write_o = a_we_i;
            ram_addr_o  = a_addr_i;
            ram_wdata_o = a_wdata_i;
            ram_wmask_o = a_wmask_i;
            push_v      = ~a_we_i;
        end else if (b_gnt) begin
            ram_req_o   = 1'b1;
            ram_write_o = b_we_i;
            ram_addr_o  = b_addr_i;
            ram_wdata_o = b_wdata_i;
            ram_wmask_o = b_wmask_i;
            push_v      = ~b_we_i;
            push_id     = ID_B;
`ifdef SRAM_1P_ARB_SCRUB_EN
        end else if (s_gnt) begin
            ram_req_o   = 1'b1;
            ram_write_o = (state_q == S_WB);
            ram_addr_o  = (state_q == S_WB) ? waddr_q : saddr_q;
            ram_wdata_o = wbdata_q;
            ram_wmask_o = '1;
            push_v      = (state_q == S_RD);
            push_id     = ID_SCRUB;
`endif
        end
    end

    // Responses are ignored for Latency cycles after reset so reads launched
    // before reset cannot be misrouted or flagged as protocol errors.
    assign tail_v     = tv_q[Latency-1];
    assign tail_id    = tid_q[Latency-1];
    assign rsp_v      = ~rst_i & (blank_q == 2'd0) & ram_rvalid_i & tail_v;
    assign a_rvalid_o = rsp_v & (tail_id == ID_A);
    assign b_rvalid_o = rsp_v & (tail_id == ID_B);
    assign a_rdata_o  = ram_rdata_i;
    assign b_rdata_o  = ram_rdata_i;
    assign a_rerror_o = ram_rerror_i;
    assign b_rerror_o = ram_rerror_i;
    assign proto_err_o = proto_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_b_q    <= 1'b1;
            tv_q        <= '0;
            blank_q     <= 2'(Latency);
            proto_err_q <= 1'b0;
            for (int i = 0; i < Latency; i++) tid_q[i] <= ID_A;
        end else begin
            last_b_q <= last_b_d;
            tv_q[0]  <= push_v;
            tid_q[0] <= push_id;
            for (int i = 1; i < Latency; i++) begin
                tv_q[i]  <= tv_q[i-1];
                tid_q[i] <= tid_q[i-1];
            end
            if (blank_q != 2'd0) blank_q <= blank_q - 2'd1;
            else if (ram_rvalid_i != tail_v) proto_err_q <= 1'b1;
        end
    end

`ifdef SRAM_1P_ARB_SCRUB_EN
    always_comb begin
        state_d  = state_q;
        icnt_d   = icnt_q;
        scnt_d   = scnt_q;
        saddr_d  = saddr_q;
        waddr_d  = waddr_q;
        wbdata_d = wbdata_q;
        cancel_d = cancel_q;
        case (state_q)
            S_IDLE: begin
                if (ab_req) begin
                    icnt_d = 16'd0;
                end else if (icnt_q == 16'(ScrubInterval - 1)) begin
                    icnt_d  = 16'd0;
                    state_d = S_RD;
                end else begin
                    icnt_d = icnt_q + 16'd1;
                end
            end
            S_RD: begin
                if (s_gnt) begin
                    waddr_d  = saddr_q;
                    cancel_d = 1'b0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // A cancelled read still waits for its response so the tag drains.
                if (ab_wr_hit) cancel_d = 1'b1;
                if (s_rsp) begin
                    saddr_d = (saddr_q == Aw'(Depth - 1)) ? '0 : saddr_q + Aw'(1);
                    if (ram_rerror_i == 2'b01 && !cancel_q && !ab_wr_hit) begin
                        wbdata_d = ram_rdata_i;
                        state_d  = S_WB;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                if (ab_wr_hit) begin
                    state_d = S_IDLE;
                end else if (s_gnt) begin
                    if (scnt_q != 16'hFFFF) scnt_d = scnt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            icnt_q   <= '0;
            scnt_q   <= '0;
            saddr_q  <= '0;
            waddr_q  <= '0;
            wbdata_q <= '0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            icnt_q   <= icnt_d;
            scnt_q   <= scnt_d;
            saddr_q  <= saddr_d;
            waddr_q  <= waddr_d;
            wbdata_q <= wbdata_d;
            cancel_q <= cancel_d;
        end
    end

    assign scrub_cnt_o = scnt_q;
`else
    assign scrub_cnt_o = 16'd0;
`endif
endmodule
